// File: rtl/moore_seq_pkg.sv
// Shared constants and elaboration-time helpers for the Moore serial pattern detector.
// The transition table is derived from the pattern with a KMP prefix (failure) table.
package moore_seq_pkg;

   localparam int         DEF_PAT_LEN = 3;
   localparam logic [2:0] DEF_PATTERN = 3'b101;
   localparam int         MAX_PAT_LEN = 16;

   // State encodings for the default "101" pattern.
   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_GOT1  = 2'b01;
   localparam logic [1:0] S_GOT10 = 2'b10;
   localparam logic [1:0] S_MATCH = 2'b11;

   typedef logic [MAX_PAT_LEN:0][4:0] fail_tbl_t;
   typedef logic [31:0][1:0][4:0]     next_tbl_t;

   function automatic int state_width(input int pat_len);
      return $clog2(pat_len + 1);
   endfunction

   // Pattern bit k, counted from the first bit received (the MSB).
   function automatic logic pat_bit(input logic [15:0] pattern, input int pat_len, input int k);
      logic [15:0] sh;
      sh = pattern >> (pat_len - 1 - k);
      return sh[0];
   endfunction

   // fail[k] = length of the longest proper prefix of pattern[0..k-1] that is also its suffix.
   function automatic fail_tbl_t build_fail_table(input logic [15:0] pattern, input int pat_len);
      fail_tbl_t f;
      int        j;
      f = '0;
      for (int i = 1; i < pat_len; i++) begin
         j = int'(f[i]);
         while (j > 0 && pat_bit(pattern, pat_len, i) != pat_bit(pattern, pat_len, j))
            j = int'(f[j]);
         if (pat_bit(pattern, pat_len, i) == pat_bit(pattern, pat_len, j))
            j++;
         f[i+1] = 5'(j);
      end
      return f;
   endfunction

   // next[k][b]: successor of Sk on input bit b. Rows past pat_len stay 0, so unused
   // encodings fall back to S0.
   function automatic next_tbl_t build_next_table(input logic [15:0] pattern, input int pat_len,
                                                  input bit overlap);
      next_tbl_t n;
      fail_tbl_t f;
      logic      bv;
      n = '0;
      f = build_fail_table(pattern, pat_len);
      for (int k = 0; k <= pat_len; k++) begin
         for (int b = 0; b < 2; b++) begin
            bv = (b == 1);
            if (k < pat_len && pat_bit(pattern, pat_len, k) == bv)
               n[k][b] = 5'(k + 1);
            else if (k == pat_len && !overlap)
               n[k][b] = n[0][b];
            else if (k == 0)
               n[k][b] = 5'd0;
            else
               n[k][b] = n[f[k]][b];
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/moore_seq_det_counter.sv
// Saturating 16-bit count of cycles in which the detect flag is high.
module moore_seq_det_counter (
   input  logic        clock,
   input  logic        reset,
   input  logic        det,
   output logic [15:0] count
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (det && count != 16'hFFFF)
         count <= count + 16'd1;
   end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector (default "101", optional overlap); det decodes state only.
// Define MOORE_DET_COUNT_EN to add the saturating det_count output.
module moore_seq_detector
   import moore_seq_pkg::*;
#(
   parameter int               PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
   parameter bit               OVERLAP = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in,
`ifdef MOORE_DET_COUNT_EN
   output logic [15:0] det_count,
`endif
   output logic        det
);

   localparam int               SW     = state_width(PAT_LEN);
   localparam logic [SW-1:0]    S_LAST = SW'(PAT_LEN);
   localparam next_tbl_t        NXT    = build_next_table(16'(PATTERN), PAT_LEN, OVERLAP);

   logic [SW-1:0] state;
   logic [SW-1:0] state_next;

   // NOTE: state is updated with non-blocking assignments under an asynchronous reset;
   // reset acts on its falling edge without waiting for the clock.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= '0;
      else
         state <= state_next;
   end

   // NOTE: every always_comb output is assigned on every path (here by a single table
   // lookup), so no latch can be inferred.
   always_comb begin
      state_next = SW'(NXT[5'(state)][in]);
   end

   always_comb begin
      det = (state == S_LAST);
   end

`ifdef MOORE_DET_COUNT_EN
   moore_seq_det_counter u_counter (
      .clock (clock),
      .reset (reset),
      .det   (det),
      .count (det_count)
   );
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Self-checking bench: two detectors ("101", overlap on/off) share one input stream and
// are compared against a history-based reference model.
module tb_moore_seq_detector;

   localparam int L = 3;

   logic clock;
   logic reset;
   logic in;
   logic det_ov;
   logic det_no;
`ifdef MOORE_DET_COUNT_EN
   logic [15:0] count_ov;
   logic [15:0] count_no;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   bit pat_seq [L] = '{1'b1, 1'b0, 1'b1};
   bit hist_ov [$];
   bit hist_no [$];
   bit clear_no;
   int exp_ov;
   int exp_no;

   moore_seq_detector #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1)) dut_ov (
      .clock     (clock),
      .reset     (reset),
      .in        (in),
`ifdef MOORE_DET_COUNT_EN
      .det_count (count_ov),
`endif
      .det       (det_ov)
   );

   moore_seq_detector #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0)) dut_no (
      .clock     (clock),
      .reset     (reset),
      .in        (in),
`ifdef MOORE_DET_COUNT_EN
      .det_count (count_no),
`endif
      .det       (det_no)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Longest pattern prefix (capped at L) that ends the received history.
   function automatic int best_prefix(input bit q[$]);
      int n;
      int lim;
      bit ok;
      n   = q.size();
      lim = (n < L) ? n : L;
      for (int k = lim; k >= 1; k--) begin
         ok = 1'b1;
         for (int i = 0; i < k; i++)
            if (q[n-k+i] != pat_seq[i]) ok = 1'b0;
         if (ok) return k;
      end
      return 0;
   endfunction

   task automatic model_reset();
      hist_ov.delete();
      hist_no.delete();
      clear_no = 1'b0;
      exp_ov   = 0;
      exp_no   = 0;
   endtask

   // Without overlap a completed match consumes its bits: the history restarts empty.
   task automatic model_push(input bit b);
      hist_ov.push_back(b);
      if (hist_ov.size() > 32) void'(hist_ov.pop_front());
      exp_ov = best_prefix(hist_ov);
      if (clear_no) hist_no.delete();
      hist_no.push_back(b);
      if (hist_no.size() > 32) void'(hist_no.pop_front());
      exp_no   = best_prefix(hist_no);
      clear_no = (exp_no == L);
   endtask

   task automatic drive_bit(input bit b);
      in = b;
      @(posedge clock);
      #1;
      model_push(b);
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset = 1'b0;
      #2;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in    = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if (dut_ov.state !== 2'b00 || det_ov !== 1'b0 || dut_no.state !== 2'b00 || det_no !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_async: ov state=%b det=%b no state=%b det=%b, want 00/0", dut_ov.state, det_ov, dut_no.state, det_no);
      end
      @(posedge clock);
      #1;
      tests_run++;
      if (dut_ov.state !== 2'b00 || det_ov !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_hold: state=%b det=%b, want 00/0", dut_ov.state, det_ov);
      end
      @(negedge clock);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      bit       bits   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      bit [1:0] states [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
      bit       dets   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         drive_bit(bits[i]);
         tests_run++;
         if (dut_ov.state !== states[i] || det_ov !== dets[i] || dut_no.state !== states[i] || det_no !== dets[i]) begin
            tests_failed++;
            $display("FAIL basic[%0d]: ov %b/%b no %b/%b, want %b/%b", i, dut_ov.state, det_ov, dut_no.state, det_no, states[i], dets[i]);
         end
      end
   endtask

   task automatic test_overlap();
      bit bits   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bit det_o  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      bit det_n  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         drive_bit(bits[i]);
         tests_run++;
         if (det_ov !== det_o[i] || det_no !== det_n[i] || dut_ov.state !== 2'(exp_ov) || dut_no.state !== 2'(exp_no)) begin
            tests_failed++;
            $display("FAIL overlap[%0d]: det ov=%b no=%b state ov=%0d no=%0d, want det %b/%b state %0d/%0d",
                     i, det_ov, det_no, dut_ov.state, dut_no.state, det_o[i], det_n[i], exp_ov, exp_no);
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      drive_bit(1'b1);
      drive_bit(1'b0);
      #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if (dut_ov.state !== 2'b00 || det_ov !== 1'b0 || dut_no.state !== 2'b00 || det_no !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: ov %b/%b no %b/%b, want 00/0", dut_ov.state, det_ov, dut_no.state, det_no);
      end
      @(negedge clock);
      reset = 1'b1;
      model_reset();
      drive_bit(1'b1);
      tests_run++;
      if (dut_ov.state !== 2'b01 || det_ov !== 1'b0 || dut_no.state !== 2'b01 || det_no !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_resume: ov %b/%b no %b/%b, want 01/0", dut_ov.state, det_ov, dut_no.state, det_no);
      end
   endtask

   task automatic test_non_match();
      bit       bits   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      bit [1:0] states [6] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         drive_bit(bits[i]);
         tests_run++;
         if (dut_ov.state !== states[i] || det_ov !== 1'b0 || dut_no.state !== states[i] || det_no !== 1'b0) begin
            tests_failed++;
            $display("FAIL non_match[%0d]: ov %b/%b no %b/%b, want %b/0", i, dut_ov.state, det_ov, dut_no.state, det_no, states[i]);
         end
      end
   endtask

   task automatic test_random();
      bit b;
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         b = 1'($urandom_range(0, 1));
         drive_bit(b);
         tests_run++;
         if (dut_ov.state !== 2'(exp_ov) || det_ov !== (exp_ov == L) ||
             dut_no.state !== 2'(exp_no) || det_no !== (exp_no == L)) begin
            tests_failed++;
            $display("FAIL random[%0d]: ov %0d/%b no %0d/%b, want %0d/%b %0d/%b", i, dut_ov.state, det_ov,
                     dut_no.state, det_no, exp_ov, exp_ov == L, exp_no, exp_no == L);
         end
      end
   endtask

`ifdef MOORE_DET_COUNT_EN
   task automatic test_counter();
      apply_reset();
      for (int r = 0; r < 3; r++) begin
         drive_bit(1'b1);
         drive_bit(1'b0);
         drive_bit(1'b1);
      end
      drive_bit(1'b0);
      tests_run++;
      if (count_no !== 16'd3 || count_ov !== 16'd3) begin
         tests_failed++;
         $display("FAIL counter_three: ov=%0d no=%0d, want 3", count_ov, count_no);
      end
      @(negedge clock);
      force dut_no.u_counter.count = 16'hFFFE;
      #1;
      release dut_no.u_counter.count;
      for (int r = 0; r < 3; r++) begin
         drive_bit(1'b1);
         drive_bit(1'b0);
         drive_bit(1'b1);
      end
      drive_bit(1'b0);
      tests_run++;
      if (count_no !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL counter_saturate: got %h, want ffff", count_no);
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_overlap();
      test_reset_mid();
      test_non_match();
      test_random();
`ifdef MOORE_DET_COUNT_EN
      test_counter();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
